// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares one common data bus among NUM_REQ functional units.
// Each unit parks its finished result in a one-entry slot; every cycle at most
// one occupied slot is picked round-robin and broadcast on the CDB. A granted
// slot may take a new result in the same cycle, so one unit can stream at one
// broadcast per cycle. A mispredict flush discards every pending result.
module cdb_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int PR_WIDTH      = 6,
  parameter int ROB_IDX_WIDTH = 4,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*PR_WIDTH-1:0]       req_pd,
  input  logic [NUM_REQ*5-1:0]              req_rd,
  input  logic [NUM_REQ*ROB_IDX_WIDTH-1:0]  req_rob,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
  output logic                              cdb_valid,
  output logic [PR_WIDTH-1:0]               cdb_phys_reg,
  output logic [4:0]                        cdb_arch_reg,
  output logic [ROB_IDX_WIDTH-1:0]          cdb_rob_idx,
  output logic [DATA_WIDTH-1:0]             cdb_data,
  output logic [NUM_REQ-1:0]                cdb_grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Slot occupancy, payload storage and round-robin pointer
  logic [NUM_REQ-1:0]       slot_valid_r;
  logic [PR_WIDTH-1:0]      slot_pd_r   [NUM_REQ];
  logic [4:0]               slot_rd_r   [NUM_REQ];
  logic [ROB_IDX_WIDTH-1:0] slot_rob_r  [NUM_REQ];
  logic [DATA_WIDTH-1:0]    slot_data_r [NUM_REQ];
  logic [PTR_W-1:0]         rr_ptr_r;

  // Arbitration and handshake nets
  logic                     any_s;
  logic [PTR_W-1:0]         win_s;
  logic                     cdb_valid_s;
  logic [NUM_REQ-1:0]       grant_s;
  logic [NUM_REQ-1:0]       ready_s;
  logic [NUM_REQ-1:0]       accept_s;
  logic [PTR_W-1:0]         rr_ptr_next_s;
  logic [PR_WIDTH-1:0]      out_pd_s;
  logic [4:0]               out_rd_s;
  logic [ROB_IDX_WIDTH-1:0] out_rob_s;
  logic [DATA_WIDTH-1:0]    out_data_s;

  // Round-robin scan: first occupied slot at or after rr_ptr (wrapping) wins
  always_comb begin
    int  idx_v;
    logic hit_v;
    idx_v = 0;
    hit_v = 1'b0;
    any_s = 1'b0;
    win_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_v = (int'(rr_ptr_r) + i) % NUM_REQ;
      hit_v = slot_valid_r[idx_v] && !any_s;
      win_s = hit_v ? PTR_W'(idx_v) : win_s;
      any_s = any_s | slot_valid_r[idx_v];
    end
  end

  // Broadcast qualification, one-hot grant and payload mux (zero when idle)
  always_comb begin
    cdb_valid_s = any_s && !flush && !rst;
    grant_s     = '0;
    out_pd_s    = '0;
    out_rd_s    = 5'd0;
    out_rob_s   = '0;
    out_data_s  = '0;
    if (cdb_valid_s) begin
      grant_s[win_s] = 1'b1;
      out_pd_s       = slot_pd_r[win_s];
      out_rd_s       = slot_rd_r[win_s];
      out_rob_s      = slot_rob_r[win_s];
      out_data_s     = slot_data_r[win_s];
    end else begin
      grant_s        = '0;
    end
  end

  // A slot can accept when empty or being drained this cycle; never during flush/reset
  always_comb begin
    ready_s  = '0;
    accept_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready_s[i]  = !flush && !rst && (!slot_valid_r[i] || grant_s[i]);
      accept_s[i] = req_valid[i] && ready_s[i];
    end
  end

  // Pointer moves just past the winner after a grant, otherwise holds
  always_comb begin
    rr_ptr_next_s = rr_ptr_r;
    if (cdb_valid_s) begin
      if (win_s == PTR_W'(NUM_REQ - 1)) begin
        rr_ptr_next_s = '0;
      end else begin
        rr_ptr_next_s = win_s + PTR_W'(1);
      end
    end else begin
      rr_ptr_next_s = rr_ptr_r;
    end
  end

  // Occupancy and pointer: reset beats flush; accept wins over drain on the same slot
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_r <= '0;
      rr_ptr_r     <= '0;
    end else if (flush) begin
      slot_valid_r <= '0;
      rr_ptr_r     <= '0;
    end else begin
      slot_valid_r <= accept_s | (slot_valid_r & ~grant_s);
      rr_ptr_r     <= rr_ptr_next_s;
    end
  end

  // Payload capture on accept; payload contents are don't-care while the slot is empty
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept_s[i]) begin
        slot_pd_r[i]   <= req_pd[i*PR_WIDTH +: PR_WIDTH];
        slot_rd_r[i]   <= req_rd[i*5 +: 5];
        slot_rob_r[i]  <= req_rob[i*ROB_IDX_WIDTH +: ROB_IDX_WIDTH];
        slot_data_r[i] <= req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign req_ready    = ready_s;
  assign cdb_valid    = cdb_valid_s;
  assign cdb_grant    = grant_s;
  assign cdb_phys_reg = out_pd_s;
  assign cdb_arch_reg = out_rd_s;
  assign cdb_rob_idx  = out_rob_s;
  assign cdb_data     = out_data_s;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among NUM_REQ functional units (ALU, MUL/DIV, load, branch).
- Each unit hands its completed result into a one-entry holding slot.
- Each cycle the arbiter selects at most one occupied slot, round-robin, and broadcasts it to the RAT, reservation stations, ROB and physical register file.
- Sits between the functional-unit outputs and the CDB consumers; a mispredict flush discards all pending results.

Parameters:
NUM_REQ, 4, number of requesting functional units (>=2)
PR_WIDTH, 6, physical register index width
ROB_IDX_WIDTH, 4, ROB index width
DATA_WIDTH, 32, result data width

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
flush  input  1  branch-mispredict flush, synchronous
req_valid  input  NUM_REQ  per-unit result valid
req_ready  output  NUM_REQ  per-unit slot can accept this cycle
req_pd  input  NUM_REQ x PR_WIDTH  destination physical register
req_rd  input  NUM_REQ x 5  destination architectural register
req_rob  input  NUM_REQ x ROB_IDX_WIDTH  ROB index
req_data  input  NUM_REQ x DATA_WIDTH  result value
cdb_valid  output  1  broadcast valid this cycle
cdb_phys_reg  output  PR_WIDTH  broadcast physical register
cdb_arch_reg  output  5  broadcast architectural register
cdb_rob_idx  output  ROB_IDX_WIDTH  broadcast ROB index
cdb_data  output  DATA_WIDTH  broadcast value
cdb_grant  output  NUM_REQ  one-hot winning slot (all zero when idle)

Behaviour:
- State:
  - Per-slot slot_valid[i] plus payload {pd, rd, rob, data}.
  - Round-robin pointer rr_ptr, width clog2(NUM_REQ).
- Reset (rst=1 at posedge):
  - All slot_valid=0, rr_ptr=0.
  - While rst is high: cdb_valid=0, cdb_grant=0, req_ready=0, and other cdb_* outputs are 0.
- Arbitration (combinational from slot state):
  - Scan slots starting at rr_ptr, wrapping modulo NUM_REQ; the first occupied slot wins.
  - cdb_grant is one-hot on the winner; cdb_* carry the winner's payload.
  - cdb_valid=1 iff any slot is occupied and neither flush nor rst is asserted.
  - When cdb_valid=0, cdb_* payload outputs are 0.
- Pointer update: after a grant to slot w, rr_ptr <= (w+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Handshake:
  - req_ready[i] = !flush && !rst && (!slot_valid[i] || cdb_grant[i]). This is combinational, so a granted slot accepts a new result in the same cycle.
  - Accept when req_valid[i] && req_ready[i]: the slot loads the payload at the next edge and slot_valid[i] stays or becomes 1.
  - Granted without a new accept: slot_valid[i] <= 0.
  - Units hold their payload stable while req_valid=1 and req_ready=0.
- Latency:
  - A result accepted at edge N is broadcast no earlier than the cycle following edge N (one cycle through the slot).
  - A single active unit sustains one broadcast per cycle.
- Fairness: an occupied slot is granted within NUM_REQ cycles; at most NUM_REQ-1 other grants precede it.
- rd = x0 results are broadcast normally; the ROB needs completion, and consumers ignore x0.
- Flush:
  - In the flush cycle there is no broadcast and no accept.
  - At the next edge all slot_valid <= 0 and rr_ptr <= 0.
  - rst has priority over flush.
- Simultaneous grant + accept on the same slot: the new payload replaces the old. The old payload was broadcast this cycle and is never lost or duplicated.
- No combinational path from req_valid to cdb_*; cdb_* depend only on slot state, rr_ptr, flush and rst.

Test Plan:
- Reset, then idle: after rst, cdb_valid=0, cdb_grant=0, req_ready=4'b1111 with no requests.
- Single accept: unit 1 presents pd=6'd37, rd=5'd10, rob=4'd3, data=32'hDEADBEEF at cycle N. In cycle N+1: cdb_valid=1, cdb_grant=4'b0010, all fields match. In cycle N+2: cdb_valid=0.
- Contention: all 4 units present in the same cycle with rr_ptr=0. Grants occur in order 0,1,2,3 over 4 consecutive cycles, and rr_ptr=0 afterwards. req_ready for unit i is low until its grant cycle.
- Streaming + fairness: unit 0 presents every cycle and unit 2 presents once. Unit 2 is granted within 2 cycles of its slot filling; unit 0 then resumes one broadcast per cycle with no dropped or duplicated rob indices.
- Flush mid-traffic: slots 0, 2 and 3 occupied, flush=1 for one cycle. In that cycle cdb_valid=0 and req_ready=0. In the next cycle cdb_valid=0 and req_ready=4'b1111; no stale broadcast ever appears.
- Grant+accept same cycle: unit 3 is granted rob=5 while presenting rob=6. rob=5 is broadcast this cycle and rob=6 in the next cycle, each exactly once.
